// File: rtl/lc3b_types.sv
// Shared LC-3b types, including the branch predictor PHT counter and index types
// and the FSM encoding used by the PHT update sequencer.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef logic [9:0] pht_idx_t;
    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t PHT_WEAK_NT = 2'b01;
    localparam pht_ctr_t PHT_CTR_MAX = 2'b11;

    // One resolved branch as buffered between writeback and the PHT update.
    typedef struct packed {
        lc3b_word pc;
        logic     taken;
    } br_outcome_t;

    typedef enum logic {
        UPD_CLEAR,
        UPD_RUN
    } upd_state_e;

endpackage

// File: rtl/br_update_fifo.sv
// Small outcome FIFO between writeback and the PHT update pipeline.
// The caller never pushes when full and never pops when empty.
module br_update_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  br_outcome_t              push_data,
    input  logic                     pop,
    output br_outcome_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    br_outcome_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/br_pred_update_ctrl.sv
// Write-side sequencer for the global branch predictor PHT and BHR: clears the
// table after reset, then applies buffered branch outcomes as counter read-modify-writes.
module br_pred_update_ctrl
    import lc3b_types::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  lc3b_word         wb_pc,
    input  logic             wb_taken,
    output logic             wb_stall,
    input  logic             pht_busy,
    output logic [IDX_W-1:0] pht_ridx,
    input  logic [1:0]       pht_rdata,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_widx,
    output logic [1:0]       pht_wdata,
    output logic [2:0]       bhr_out,
    output logic             init_done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    function automatic pht_ctr_t sat_update(input pht_ctr_t ctr, input logic taken);
        pht_ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != PHT_CTR_MAX)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != 2'b00)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

    upd_state_e  state;
    pht_idx_t    clr_idx;
    logic [2:0]  bhr;

    br_outcome_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic            fifo_empty;
    logic            push_p0;
    logic            pop_p0;
    pht_idx_t        idx_p0;

    logic            vld_p1;
    logic            held_p1;
    logic            taken_p1;
    pht_idx_t        idx_p1;
    pht_ctr_t        hold_ctr_p1;
    pht_ctr_t        upd_ctr_p1;

    logic            vld_p2;
    pht_idx_t        idx_p2;
    pht_ctr_t        ctr_p2;

    logic            clr_we;
    logic            w_we;
    logic            unused_pc_bits;

    br_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_p0),
        .push_data ({wb_pc, wb_taken}),
        .pop       (pop_p0),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Stage R: W never stalls when the port is free, so R may pop on any free cycle.
    assign wb_stall = (fifo_count == CNT_W'(DEPTH));
    assign push_p0  = wb_valid && !wb_stall;
    assign pop_p0   = !reset && (state == UPD_RUN) && !fifo_empty && !pht_busy;
    assign idx_p0   = {head.pc[7:1], bhr};
    assign pht_ridx = pop_p0 ? idx_p0 : '0;
    assign unused_pc_bits = ^{head.pc[15:8], head.pc[0]};

    // Stage W: the PHT returns old data on read-during-write, so forward last cycle's write.
    always_comb begin
        upd_ctr_p1 = hold_ctr_p1;
        if (!held_p1) begin
            if (vld_p2 && idx_p2 == idx_p1)
                upd_ctr_p1 = sat_update(ctr_p2, taken_p1);
            else
                upd_ctr_p1 = sat_update(pht_rdata, taken_p1);
        end
    end

    assign clr_we    = !reset && (state == UPD_CLEAR) && !pht_busy;
    assign w_we      = !reset && vld_p1 && !pht_busy;
    assign pht_we    = clr_we || w_we;
    assign pht_widx  = clr_we ? clr_idx : (w_we ? idx_p1 : '0);
    assign pht_wdata = clr_we ? PHT_WEAK_NT : (w_we ? upd_ctr_p1 : '0);
    assign bhr_out   = bhr;
    assign init_done = (state == UPD_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= UPD_CLEAR;
            clr_idx <= '0;
            bhr     <= '0;
            vld_p1  <= 1'b0;
            held_p1 <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            if (clr_we) begin
                clr_idx <= clr_idx + 10'd1;
                if (clr_idx == '1) state <= UPD_RUN;
            end
            if (pop_p0) bhr <= {bhr[1:0], head.taken};
            vld_p1  <= pop_p0 || (vld_p1 && !w_we);
            held_p1 <= vld_p1 && pht_busy;
            vld_p2  <= w_we;
        end
    end

    // Stage W / forwarding payload
    always_ff @(posedge clk) begin
        if (pop_p0) begin
            idx_p1   <= idx_p0;
            taken_p1 <= head.taken;
        end
        if (vld_p1 && pht_busy) hold_ctr_p1 <= upd_ctr_p1;
        if (w_we) begin
            idx_p2 <= idx_p1;
            ctr_p2 <= upd_ctr_p1;
        end
    end

endmodule

// File: tb/tb_br_pred_update_ctrl.sv
// Directed bench for br_pred_update_ctrl with a behavioural PHT that returns
// registered read data and old data on read-during-write.
module tb_br_pred_update_ctrl;
    import lc3b_types::*;

    logic       clk;
    logic       reset;
    logic       wb_valid;
    lc3b_word   wb_pc;
    logic       wb_taken;
    logic       wb_stall;
    logic       pht_busy;
    logic [9:0] pht_ridx;
    logic [1:0] pht_rdata;
    logic       pht_we;
    logic [9:0] pht_widx;
    logic [1:0] pht_wdata;
    logic [2:0] bhr_out;
    logic       init_done;

    logic [1:0] pht_mem [1024];
    logic       mem_fill;
    int         n_vec;
    int         n_err;
    lc3b_word   push_tab [5] = '{16'h0010, 16'h0014, 16'h0018, 16'h001c, 16'h0020};

    br_pred_update_ctrl #(.DEPTH(4), .IDX_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_pc     (wb_pc),
        .wb_taken  (wb_taken),
        .wb_stall  (wb_stall),
        .pht_busy  (pht_busy),
        .pht_ridx  (pht_ridx),
        .pht_rdata (pht_rdata),
        .pht_we    (pht_we),
        .pht_widx  (pht_widx),
        .pht_wdata (pht_wdata),
        .bhr_out   (bhr_out),
        .init_done (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 1024; i++) pht_mem[i] <= 2'b10;
        end else if (pht_we) begin
            pht_mem[pht_widx] <= pht_wdata;
        end
        pht_rdata <= pht_mem[pht_ridx];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input lc3b_word pc, input logic t);
        wb_valid = v;
        wb_pc    = pc;
        wb_taken = t;
    endtask

    // Releases reset and runs until init_done, tracking the clear writes.
    task automatic run_sweep(input bit toggle_busy, input bit with_push,
                             output int nwr, output int nbad, output int init_cyc,
                             output logic stall5);
        int pi;
        pi = 0; nwr = 0; nbad = 0; init_cyc = -1; stall5 = 1'b0;
        reset = 1'b0;
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            pht_busy = toggle_busy && (cyc % 2 == 0);
            if (with_push && pi < 5) drive_wb(1'b1, push_tab[pi], 1'b1);
            else                     drive_wb(1'b0, 16'h0000, 1'b0);
            #1;
            if (pht_we) begin
                if (pht_widx != 10'(nwr) || pht_wdata != PHT_WEAK_NT || pht_busy) nbad++;
                nwr++;
            end
            if (cyc == 5) stall5 = wb_stall;
            if (wb_valid && !wb_stall) pi++;
            if (init_done) begin
                init_cyc = cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int   nwr, nbad, init_cyc, nonweak, extra;
        logic stall5;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; mem_fill = 1'b1; pht_busy = 1'b0;
        drive_wb(1'b0, 16'h0000, 1'b0);
        tick();
        mem_fill = 1'b0;
        tick();
        tick();
        #1;
        check_vec("rst_stall", 32'(wb_stall), 32'd0);
        check_vec("rst_we",    32'(pht_we),    32'd0);
        check_vec("rst_widx",  32'(pht_widx),  32'd0);
        check_vec("rst_wdata", 32'(pht_wdata), 32'd0);
        check_vec("rst_ridx",  32'(pht_ridx),  32'd0);
        check_vec("rst_bhr",   32'(bhr_out),   32'd0);
        check_vec("rst_init",  32'(init_done), 32'd0);

        // Clear sweep with the port busy every other cycle
        tick();
        run_sweep(1'b1, 1'b0, nwr, nbad, init_cyc, stall5);
        check_vec("tog_nwr",  32'(nwr),      32'd1024);
        check_vec("tog_seq",  32'(nbad),     32'd0);
        check_vec("tog_init", 32'(init_cyc), 32'd2048);
        nonweak = 0;
        for (int i = 0; i < 1024; i++) if (pht_mem[i] != 2'b01) nonweak++;
        check_vec("tog_mem", 32'(nonweak), 32'd0);

        // Single taken branch, BHR = 0
        tick();
        pht_busy = 1'b0;
        drive_wb(1'b1, 16'h0012, 1'b1); #1;
        check_vec("c_stall", 32'(wb_stall), 32'd0);
        tick();
        drive_wb(1'b0, 16'h0000, 1'b0); #1;
        check_vec("c_ridx", 32'(pht_ridx), 32'h048);
        check_vec("c_we0",  32'(pht_we),   32'd0);
        tick(); #1;
        check_vec("c_we",    32'(pht_we),    32'd1);
        check_vec("c_widx",  32'(pht_widx),  32'h048);
        check_vec("c_wdata", 32'(pht_wdata), 32'h2);
        check_vec("c_bhr",   32'(bhr_out),   32'h1);

        // Two fillers saturate BHR to 111, then two colliding takens
        tick();
        drive_wb(1'b1, 16'h0100, 1'b1); #1;
        tick();
        drive_wb(1'b1, 16'h0100, 1'b1); #1;
        check_vec("d_f1_ridx", 32'(pht_ridx), 32'h001);
        tick();
        drive_wb(1'b1, 16'h0020, 1'b1); #1;
        check_vec("d_f1_widx",  32'(pht_widx),  32'h001);
        check_vec("d_f1_wdata", 32'(pht_wdata), 32'h2);
        tick();
        drive_wb(1'b1, 16'h0020, 1'b1); #1;
        check_vec("d_x_ridx", 32'(pht_ridx), 32'h087);
        tick();
        drive_wb(1'b0, 16'h0000, 1'b0); #1;
        check_vec("d_y_ridx",  32'(pht_ridx),  32'h087);
        check_vec("d_x_widx",  32'(pht_widx),  32'h087);
        check_vec("d_x_wdata", 32'(pht_wdata), 32'h2);
        tick(); #1;
        check_vec("d_y_we",    32'(pht_we),    32'd1);
        check_vec("d_y_widx",  32'(pht_widx),  32'h087);
        check_vec("d_y_fwd",   32'(pht_wdata), 32'h3);
        check_vec("d_bhr",     32'(bhr_out),   32'h7);

        // Port busy for three cycles while W holds an update
        tick();
        drive_wb(1'b1, 16'h0020, 1'b1); #1;
        tick();
        drive_wb(1'b1, 16'h0020, 1'b1); #1;
        check_vec("e_ridx", 32'(pht_ridx), 32'h087);
        for (int k = 0; k < 3; k++) begin
            tick();
            drive_wb(1'b0, 16'h0000, 1'b0);
            pht_busy = 1'b1; #1;
            check_vec("e_busy_we",  32'(pht_we),   32'd0);
            check_vec("e_busy_pop", 32'(pht_ridx), 32'd0);
        end
        tick();
        pht_busy = 1'b0; #1;
        check_vec("e_held_we",    32'(pht_we),    32'd1);
        check_vec("e_held_widx",  32'(pht_widx),  32'h087);
        check_vec("e_held_wdata", 32'(pht_wdata), 32'h3);

        // Reset while updates are in flight
        tick();
        drive_wb(1'b1, 16'h0100, 1'b0); #1;
        tick();
        drive_wb(1'b1, 16'h0100, 1'b0); #1;
        tick();
        drive_wb(1'b0, 16'h0000, 1'b0);
        reset = 1'b1; #1;
        check_vec("f_rst_we", 32'(pht_we), 32'd0);
        tick(); #1;
        check_vec("f_rst_bhr",   32'(bhr_out),  32'd0);
        check_vec("f_rst_stall", 32'(wb_stall), 32'd0);
        tick();
        run_sweep(1'b0, 1'b0, nwr, nbad, init_cyc, stall5);
        check_vec("f_nwr",  32'(nwr),      32'd1024);
        check_vec("f_seq",  32'(nbad),     32'd0);
        check_vec("f_init", 32'(init_cyc), 32'd1025);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pht_we) extra++;
        end
        check_vec("f_no_stale", 32'(extra), 32'd0);

        // Five pushes during the clear sweep
        reset = 1'b1;
        tick();
        tick();
        run_sweep(1'b0, 1'b1, nwr, nbad, init_cyc, stall5);
        check_vec("g_stall5",    32'(stall5),    32'd1);
        check_vec("g_nwr",       32'(nwr),       32'd1024);
        check_vec("g_seq",       32'(nbad),      32'd0);
        check_vec("g_init",      32'(init_cyc),  32'd1025);
        check_vec("g_stall_run", 32'(wb_stall),  32'd1);
        check_vec("g_first_pop", 32'(pht_ridx),  32'h040);
        tick(); #1;
        check_vec("g_accept5",   32'(wb_stall),  32'd0);
        tick();
        drive_wb(1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 10; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
